// File: rtl/execute_div_pkg.sv
// Shared scalar typedefs and execute-stage timing constants.
// DIV_LATENCY is the number of cycles from first valid to done for execute_div.
package execute_div_pkg;

  typedef logic        i1;
  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/execute_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU: c = {remainder, quotient}.
// 33 cycles from accepted request to done; valid is held until done, inputs sampled only at acceptance.
module execute_div
  import execute_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam int             CW   = $clog2(ITER);
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dvs, a_raw;
  i1                neg_q, neg_r, div0;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] q_out, r_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done = (state_nxt == IDLE);
  end

  // The shifted partial remainder keeps the bit that falls out of rem, so
  // divisors above 2^(WIDTH-1) still compare correctly.
  always_comb begin
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs};
    rem_ge    = (rem_shift >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (valid) begin
          quo   <= a_mag;
          rem   <= '0;
          dvs   <= b_mag;
          a_raw <= a;
          neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= is_signed & a[WIDTH-1];
          div0  <= (b == '0);
          cnt   <= '0;
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], rem_ge};
          rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_out = neg_q ? -quo : quo;
    r_out = neg_r ? -rem : rem;
    c     = div0 ? {a_raw, {WIDTH{1'b1}}} : {r_out, q_out};
  end

endmodule

// File: tb/tb_execute_div.sv
// Directed-vector bench for execute_div: latency, signed/unsigned results, div-by-zero, reset abort, back-to-back.
module tb_execute_div;
  import execute_div_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic valid;
  logic is_signed;
  i32   a, b;
  logic done;
  i64   c;

  int checks = 0;
  int errors = 0;

  execute_div #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .done      (done),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; the current cycle is the acceptance cycle.
  task automatic do_req(input string tag, input i32 ta, input i32 tb_v, input logic sgn,
                        input i64 exp, input bit drop, input bit scramble);
    int lat;
    valid     = 1'b1;
    a         = ta;
    b         = tb_v;
    is_signed = sgn;
    lat       = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      if (scramble && k == 9) begin
        a         = 32'hDEAD_BEEF;
        b         = 32'h0000_0003;
        is_signed = ~sgn;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(DIV_LATENCY));
    check({tag, " result"}, c, exp);
    @(posedge clk); #1;
    if (drop) valid = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    valid     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    check("reset done idle", 64'(done), 64'd1);
    check("reset c", c, 64'd0);
    valid = 1'b1;
    #1;
    check("reset done valid", 64'(done), 64'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // 100/7 unsigned, then valid dropped: done stays high, c holds.
    do_req("u100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b1, 1'b0);
    @(negedge clk);
    check("hold done", 64'(done), 64'd1);
    check("hold c", c, {32'd2, 32'd14});
    @(posedge clk); #1;

    do_req("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("u bigdiv", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, {32'h7FFF_FFFE, 32'h1}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("s div0", 32'h1234_5678, 32'h0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_req("u div0", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Reset at cycle 10 of a 100/7 request.
    valid     = 1'b1;
    a         = 32'd100;
    b         = 32'd7;
    is_signed = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midreset done", 64'(done), 64'd0);
    check("midreset c", c, 64'd0);
    valid = 1'b0;
    #1;
    check("midreset done idle", 64'(done), 64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_req("after reset", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Back-to-back with valid held; operands scrambled mid-RUN must be ignored.
    do_req("b2b first", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b0, 1'b1);
    do_req("b2b second", 32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
